// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between instruction fetch (IF) and the memory stage (MEM).
// Single-cycle latency; MEM has priority unless IF has been starved for STARVE_LIMIT cycles.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        flush,
    input  logic        mem_req,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic [1:0]  dbg_owner
);

    // Handshake: a requester holds req/addr/data until it sees gnt in the same cycle;
    // the response (rvalid) always follows exactly one cycle after the grant.

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    owner_t     owner_q;
    owner_t     owner_d;
    logic [2:0] starve_cnt;
    logic       active;
    logic       if_win;
    logic       mem_win;

    // Grants stay off until the first clock edge after reset is released.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    always_comb begin
        if_win  = 1'b0;
        mem_win = 1'b0;
        if (resetn && active) begin
            if (if_req && (!mem_req || starve_cnt == LIMIT)) begin
                if_win = 1'b1;
            end else if (mem_req) begin
                mem_win = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= 3'd0;
        end else if (if_req && !if_win) begin
            if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end else begin
            starve_cnt <= 3'd0;
        end
    end

    // Owner FSM: state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Owner FSM: next state is simply this cycle's winner
    always_comb begin
        owner_d = OWN_NONE;
        if (if_win) begin
            owner_d = OWN_IF;
        end else if (mem_win) begin
            owner_d = OWN_MEM;
        end
    end

    // Owner FSM: outputs
    always_comb begin
        if_gnt     = if_win;
        mem_gnt    = mem_win;
        ram_en     = if_win | mem_win;
        ram_wen    = 4'b0000;
        ram_addr   = if_addr;
        ram_wdata  = mem_wdata;
        if (mem_win) begin
            ram_wen  = mem_wen;
            ram_addr = mem_addr;
        end
        // flush kills only the IF response landing this cycle, never a new grant
        if_rvalid  = (owner_q == OWN_IF) && !flush;
        mem_rvalid = (owner_q == OWN_MEM);
        if_rdata   = ram_rdata;
        mem_rdata  = ram_rdata;
        dbg_owner  = owner_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a RAM model and a
// transaction-level reference (grant rules, starvation count, expected-data queues).
module tb_mem_port_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        flush;
    logic        mem_req;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [1:0]  dbg_owner;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .flush(flush),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .ram_en(ram_en), .ram_wen(ram_wen),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .dbg_owner(dbg_owner)
    );

    // clock
    always #5 clk = ~clk;

    // ---------------- RAM model attached to the DUT ----------------
    logic [31:0] ram_store [logic [31:0]];

    function automatic logic [31:0] word_init(input logic [31:0] a);
        return (a * 32'h9e3779b9) ^ 32'h00c0ffee;
    endfunction

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen != 4'b0000) begin
                logic [31:0] w;
                w = ram_store.exists(ram_addr) ? ram_store[ram_addr] : word_init(ram_addr);
                for (int b = 0; b < 4; b++)
                    if (ram_wen[b]) w[b*8 +: 8] = ram_wdata[b*8 +: 8];
                ram_store[ram_addr] = w;
            end else begin
                ram_rdata <= ram_store.exists(ram_addr) ? ram_store[ram_addr] : word_init(ram_addr);
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_mem_q[$];
    logic        exp_mem_st_q[$];
    int          losses;
    bit          armed;
    bit          last_if_gnt;
    bit          last_mem_gnt;
    int          n_cmp;
    int          n_bad;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : word_init(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge with inputs already driven; checks this cycle, advances the model.
    task automatic step();
        logic        e_if;
        logic        e_mem;
        logic [31:0] d;
        logic [31:0] w;
        logic        st;
        #1;
        if (!resetn) begin
            exp_if_q.delete();
            exp_mem_q.delete();
            exp_mem_st_q.delete();
        end
        if (exp_if_q.size() > 0) begin
            d = exp_if_q.pop_front();
            check("if_rvalid", 32'(if_rvalid), 32'(!flush));
            if (!flush) check("if_rdata", if_rdata, d);
        end else begin
            check("if_rvalid_idle", 32'(if_rvalid), 32'd0);
        end
        if (exp_mem_q.size() > 0) begin
            d  = exp_mem_q.pop_front();
            st = exp_mem_st_q.pop_front();
            check("mem_rvalid", 32'(mem_rvalid), 32'd1);
            if (!st) check("mem_rdata", mem_rdata, d);
        end else begin
            check("mem_rvalid_idle", 32'(mem_rvalid), 32'd0);
        end

        e_if  = resetn && armed && if_req && (!mem_req || losses == int'(LIMIT));
        e_mem = resetn && armed && mem_req && !e_if;
        check("if_gnt", 32'(if_gnt), 32'(e_if));
        check("mem_gnt", 32'(mem_gnt), 32'(e_mem));
        check("ram_en", 32'(ram_en), 32'(e_if || e_mem));
        check("ram_wen", 32'(ram_wen), e_mem ? 32'(mem_wen) : 32'd0);
        if (e_if) begin
            check("ram_addr_if", ram_addr, if_addr);
            exp_if_q.push_back(ref_read(if_addr));
        end
        if (e_mem) begin
            check("ram_addr_mem", ram_addr, mem_addr);
            if (mem_wen != 4'b0000) begin
                check("ram_wdata", ram_wdata, mem_wdata);
                w = ref_read(mem_addr);
                for (int b = 0; b < 4; b++)
                    if (mem_wen[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
                ref_mem[mem_addr] = w;
                exp_mem_q.push_back(32'd0);
                exp_mem_st_q.push_back(1'b1);
            end else begin
                exp_mem_q.push_back(ref_read(mem_addr));
                exp_mem_st_q.push_back(1'b0);
            end
        end

        if (!resetn) losses = 0;
        else if (if_req && !e_if) losses = (losses + 1 > int'(LIMIT)) ? int'(LIMIT) : losses + 1;
        else losses = 0;
        armed        = resetn;
        last_if_gnt  = e_if;
        last_mem_gnt = e_mem;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'd0; flush = 1'b0;
        mem_req = 1'b0; mem_wen = 4'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    // ---------------- stimulus ----------------
    int if_wins;
    int mem_wins;

    initial begin
        n_cmp = 0; n_bad = 0; losses = 0; armed = 1'b0;
        last_if_gnt = 1'b0; last_mem_gnt = 1'b0;
        resetn = 1'b0;
        idle_inputs();
        #1;
        check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("rst_mem_rvalid", 32'(mem_rvalid), 32'd0);
        check("rst_owner", 32'(dbg_owner), 32'd0);
        @(negedge clk);
        // requests during reset must be ignored
        if_req = 1'b1; mem_req = 1'b1;
        step();
        step();
        idle_inputs();
        resetn = 1'b1;
        step();

        // single IF fetch from the boot vector
        if_req = 1'b1; if_addr = 32'hbfc00000;
        step();
        idle_inputs();
        step();

        // MEM read beats IF
        if_req = 1'b1; if_addr = 32'h00000100;
        mem_req = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h00000010;
        step();
        mem_req = 1'b0;
        step();
        idle_inputs();
        step();

        // store then read back
        mem_req = 1'b1; mem_wen = 4'b1111; mem_addr = 32'h20; mem_wdata = 32'hdeadbeef;
        step();
        mem_wen = 4'b0000; mem_wdata = 32'd0;
        step();
        idle_inputs();
        step();
        check("readback", mem_rdata, 32'hdeadbeef);

        // continuous contention: MEM x4 then IF, repeating
        if_wins = 0; mem_wins = 0;
        if_req = 1'b1; if_addr = 32'h40; mem_req = 1'b1; mem_addr = 32'h44;
        for (int c = 0; c < 15; c++) begin
            step();
            if (last_if_gnt) if_wins++;
            if (last_mem_gnt) mem_wins++;
        end
        check("starve_if_wins", 32'(if_wins), 32'd3);
        check("starve_mem_wins", 32'(mem_wins), 32'd12);
        idle_inputs();
        step();
        step();

        // flush with a new fetch in the redirect cycle
        if_req = 1'b1; if_addr = 32'h08;
        step();
        flush = 1'b1; if_addr = 32'h30;
        step();
        flush = 1'b0; if_req = 1'b0;
        step();
        check("flush_refetch", if_rdata, ref_read(32'h30));

        // reset dropped while IF owns the port
        if_req = 1'b1; if_addr = 32'h0c;
        step();
        #2 resetn = 1'b0;
        #1;
        check("async_if_rvalid", 32'(if_rvalid), 32'd0);
        check("async_ram_en", 32'(ram_en), 32'd0);
        check("async_if_gnt", 32'(if_gnt), 32'd0);
        exp_if_q.delete(); exp_mem_q.delete(); exp_mem_st_q.delete();
        losses = 0; armed = 1'b0;
        @(negedge clk);
        mem_req = 1'b1; mem_addr = 32'h10;
        step();
        resetn = 1'b1;
        step();
        step();
        idle_inputs();
        step();

        // randomized traffic; requesters hold until granted
        for (int c = 0; c < 2000; c++) begin
            if (!(if_req && !last_if_gnt)) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = rand_addr();
            end
            if (!(mem_req && !last_mem_gnt)) begin
                mem_req   = ($urandom_range(0, 1) == 1);
                mem_wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
                mem_addr  = rand_addr();
                mem_wdata = $urandom();
            end
            flush = ($urandom_range(0, 4) == 0);
            step();
        end
        idle_inputs();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
